// File: rtl/led_spi_tx.sv
// led_spi_tx: per frame pops ZONES FIFO words, shifts each MSB-first on divided led_sclk, then strobes led_le (ports: frame_start/rd_* in, led_*/busy/frame_done/underrun out)
module led_spi_tx #(
  parameter int FIFO_W = 32,
  parameter int DATA_W = 16,
  parameter int ZONES = 64,
  parameter int CLK_DIV = 4,
  parameter int LE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [FIFO_W-1:0] rd_data,
  input  logic              rd_empty,
  output logic              rd_en,
  output logic              led_sclk,
  output logic              led_sdo,
  output logic              led_le,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);
  localparam int WC_W = $clog2(ZONES + 1);
  localparam int BC_W = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam int DV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int LE_W = LE_CYCLES > 1 ? $clog2(LE_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, LATCH, DONE} state_t;
  state_t state, state_n;
  logic pending, div_last, word_end, unused_rd;
  logic [WC_W-1:0] wc;
  logic [BC_W-1:0] bc;
  logic [DV_W-1:0] div;
  logic [LE_W-1:0] le_cnt;
  logic [DATA_W-1:0] sreg, sreg_sh;
  assign rd_en = state == FETCH && !rd_empty;
  assign div_last = div == DV_W'(CLK_DIV - 1);
  assign word_end = state == SHIFT && div_last && led_sclk && bc == '0;
  assign sreg_sh = sreg << 1;
  assign unused_rd = ^rd_data;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = pending ? FETCH : IDLE;
      FETCH:   state_n = rd_empty ? FETCH : LOAD;
      LOAD:    state_n = SHIFT;
      SHIFT:   state_n = !word_end ? SHIFT : wc == WC_W'(ZONES - 1) ? LATCH : FETCH;
      LATCH:   state_n = le_cnt == LE_W'(LE_CYCLES - 1) ? DONE : LATCH;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      wc <= '0;
      bc <= '0;
      div <= '0;
      le_cnt <= '0;
      sreg <= '0;
      led_sclk <= 1'b0;
      led_sdo <= 1'b0;
      led_le <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      underrun <= 1'b0;
    end else begin
      pending <= state == IDLE && pending ? 1'b0 : pending | frame_start;
      le_cnt <= state == LATCH ? le_cnt + 1'b1 : '0;
      led_le <= state_n == LATCH;
      busy <= state_n != IDLE && state_n != DONE;
      frame_done <= state_n == DONE;
      if (state == IDLE && pending) begin
        underrun <= 1'b0;
        wc <= '0;
      end
      if (state == FETCH && rd_empty && wc != '0) underrun <= 1'b1;
      if (state == LOAD) begin
        sreg <= rd_data[DATA_W-1:0];
        bc <= BC_W'(DATA_W - 1);
        led_sdo <= rd_data[DATA_W-1];
        div <= '0;
      end
      if (state == SHIFT) begin
        div <= div_last ? '0 : div + 1'b1;
        if (div_last) led_sclk <= !led_sclk;
        if (div_last && led_sclk && bc != '0) begin
          bc <= bc - 1'b1;
          sreg <= sreg_sh;
          led_sdo <= sreg_sh[DATA_W-1];
        end
        if (word_end) wc <= wc + 1'b1;
      end
      if (state_n == LATCH) led_sdo <= 1'b0;
    end
  end
endmodule

// File: doc/led_spi_tx.md
Name: led_spi_tx

Overview:
Read-side consumer of the LED-zone FIFO in the local-dimming path. On each frame request it pops ZONES brightness words from the FIFO and shifts each word MSB-first to the cascaded LED driver chips on a divided serial clock. After the last word it pulses a latch strobe. It reports frame completion and underrun status to the dimming controller.

Parameters:
FIFO_W, 32, width of rd_data from the FIFO
DATA_W, 16, bits shifted per zone; rd_data[DATA_W-1:0] is used and upper bits are ignored (1 <= DATA_W <= FIFO_W)
ZONES, 64, words per frame (>= 1)
CLK_DIV, 4, clk cycles per led_sclk phase; led_sclk period = 2*CLK_DIV (>= 1)
LE_CYCLES, 4, width of the led_le pulse in clk cycles (>= 1)

Ports:
clk  input  1  single clock; FIFO rd_clk is driven from the same net
rst  input  1  synchronous, active-high reset
frame_start  input  1  one-cycle request to send one frame
rd_data  input  FIFO_W  FIFO read data, valid the cycle after rd_en
rd_empty  input  1  FIFO empty flag
rd_en  output  1  FIFO pop, one cycle per word
led_sclk  output  1  serial clock to the LED drivers
led_sdo  output  1  serial data; changes while led_sclk is low
led_le  output  1  latch strobe to the LED drivers
busy  output  1  high from frame accept until frame_done
frame_done  output  1  one-cycle pulse at end of frame
underrun  output  1  sticky; set by a mid-frame stall, cleared at the next frame accept

Behaviour:
- Reset (sync, rst=1 at a clk edge): state IDLE; pending, counters and shift register cleared. Outputs rd_en, led_sclk, led_sdo, led_le, busy, frame_done and underrun are all 0.
- Reset mid-frame aborts immediately with no latch pulse. Any words already popped are lost. Flushing the FIFO is the upstream block's responsibility.
- States: IDLE, FETCH, LOAD, SHIFT, LATCH, DONE.
- IDLE:
  - frame_start sets `pending`.
  - When pending=1, the block accepts the frame: clears pending and underrun, sets busy, resets the word count to 0, and moves to FETCH.
- FETCH: rd_en = (state==FETCH) & !rd_empty. This is the only combinational output.
  - If rd_empty=0: pop the word and move to LOAD.
  - If rd_empty=1: stay in FETCH. If word count > 0, set underrun. led_sclk stays 0 and led_sdo holds.
  - A frame accepted with an empty FIFO waits in FETCH and does not flag underrun.
- LOAD: capture rd_data[DATA_W-1:0] into the shift register, set bit count = DATA_W-1, drive led_sdo = MSB (registered), then go to SHIFT.
- SHIFT:
  - Each bit is a low phase of CLK_DIV cycles with led_sclk=0, then a high phase of CLK_DIV cycles with led_sclk=1.
  - At the end of the high phase, led_sclk returns to 0 and led_sdo advances to the next bit.
  - After bit 0's high phase, the word count increments. If it equals ZONES go to LATCH, otherwise go to FETCH.
  - Between words, led_sclk is held low for the 2 extra cycles of FETCH and LOAD. No prefetch is done.
- LATCH: led_le=1 for exactly LE_CYCLES cycles. led_sclk=0 and led_sdo=0.
- DONE: frame_done=1 for one cycle, busy drops to 0 on the same edge, then return to IDLE.
- frame_start while busy: sets pending, so at most one queued frame. Extra requests are merged and never counted.
- frame_start in DONE: the next frame is accepted from IDLE on the following cycle.
- Timing, with no stalls and frame_start sampled at cycle 0:
  - IDLE accepts at cycle 1, FETCH at cycle 2, LOAD at cycle 3.
  - First led_sdo is valid from cycle 4. First led_sclk rising edge is at cycle 4+CLK_DIV.
  - Per-word cost is 2 + 2*CLK_DIV*DATA_W cycles.
  - Frame length is ZONES*(2+2*CLK_DIV*DATA_W) + LE_CYCLES + 1 (DONE) cycles from FETCH entry to IDLE.
- The word count must be wide enough for ZONES (clog2(ZONES+1) bits). The bit counter is clog2(DATA_W) bits. The divider counter is clog2(CLK_DIV) bits, minimum 1.

Test Plan:
- Test parameters: DATA_W=16, ZONES=4, CLK_DIV=2, LE_CYCLES=4.
- Basic frame: preload FIFO with 0xA5A5, 0x0001, 0x8000, 0xFFFF, then frame_start.
  - Required: exactly 4 rd_en pulses, 64 led_sclk rising edges, and the bits sampled on rising edges equal those words MSB-first.
  - Required: led_le high for 4 cycles, then frame_done, with 4*66+4+1=269 cycles from FETCH entry to IDLE. underrun stays 0.
- Upper-bit masking: FIFO word 0xDEAD1234 -> shifted value is 0x1234.
- Mid-frame underrun: preload 2 words, frame_start, push 2 more words 500 cycles later.
  - Required: led_sclk held low and rd_en held 0 during the stall, underrun=1, frame completes with correct data, underrun stays 1 until the next frame accept.
- Empty at start: frame_start with an empty FIFO, then push 4 words after 100 cycles.
  - Required: busy=1 throughout, no led_sclk activity until data arrives, underrun=0.
- Queued request: frame_start pulsed 3 times during frame 1 with 8 words preloaded.
  - Required: exactly one further frame starts 1 cycle after frame_done and consumes words 5-8. No third frame.
- Reset mid-frame: assert rst during the bit-7 high phase of word 2.
  - Required: next cycle all outputs are 0, no led_le pulse, and the block idles until a new frame_start.
